id_stage_pipe: RTL and testbench

- Registered, parametrised instruction-decode stage for the RV core. Sits between fetch and EX and drives the ID/EX pipeline register directly.
- Adds the following over the combinational decoder:
  - XLEN 32/64 support
  - N-deep forwarding network with priority
  - load-use hazard detection with bubble insertion
  - valid/ready handshakes on both sides
  - flush
  - AUIPC decode
  - illegal-instruction flag
- Decodes OP, OP_IMM, LUI, AUIPC, LOAD and STORE.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/id_fwd_mux.sv | 31 +++
 rtl/id_stage_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV decode constants for the ID stage.
// Contents: major opcodes, ALU operation class codes, load/store funct3 width
// encodings, and a helper that turns a width code into a byte-enable mask.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [7:0] ALUOP_NOP    = 8'd0;
   localparam logic [7:0] ALUOP_OP     = 8'd1;
   localparam logic [7:0] ALUOP_OP_IMM = 8'd2;
   localparam logic [7:0] ALUOP_LUI    = 8'd3;
   localparam logic [7:0] ALUOP_AUIPC  = 8'd4;
   localparam logic [7:0] ALUOP_LOAD   = 8'd5;
   localparam logic [7:0] ALUOP_STORE  = 8'd6;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_SR = 3'b101;   // shift-right group, inst[30] picks arith/logical

   // Width code -> byte-enable mask for a 64-bit lane; callers truncate for XLEN=32.
   function automatic logic [7:0] be_from_width(input logic [1:0] width);
      logic [7:0] be;
      case (width)
         2'b00:   be = 8'h01;
         2'b01:   be = 8'h03;
         2'b10:   be = 8'h0F;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source select for one register read port.
// Ports: rs_addr_i (architectural register), rf_data_i (regfile read data),
// fwd_we_i/fwd_addr_i/fwd_data_i (flattened forwarding sources, index 0 is
// the nearest stage), rs_val_o (selected operand).
// x0 always reads zero; otherwise the lowest-index matching source wins.
module id_fwd_mux #(
   parameter int XLEN    = 64,
   parameter int NUM_FWD = 2
) (
   input  logic [4:0]              rs_addr_i,
   input  logic [XLEN-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]      fwd_we_i,
   input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
   output logic [XLEN-1:0]         rs_val_o
);

   // Walk from the farthest source down so the nearest match is assigned last.
   always_comb begin
      rs_val_o = rf_data_i;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we_i[i] && (fwd_addr_i[5*i +: 5] == rs_addr_i)) begin
            rs_val_o = fwd_data_i[XLEN*i +: XLEN];
         end
      end
      if (rs_addr_i == 5'd0) begin
         rs_val_o = '0;
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage feeding the ID/EX pipeline register.
// Ports: clk/rst_n; fetch side in_valid/in_ready/in_inst/in_pc; flush;
// regfile rs1_addr/rs2_addr/rs1_data/rs2_data; forwarding fwd_we/fwd_addr/
// fwd_data; load-use inputs ex_is_load/ex_rd; EX side out_valid/out_ready
// and the decoded out_* payload.
// Decodes OP, OP_IMM, LUI, AUIPC, LOAD, STORE; anything else is passed down
// as a valid op with out_illegal set so the trap is taken in order.
module id_stage_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int NUM_FWD = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_inst,
   input  logic [XLEN-1:0]         in_pc,
   input  logic                    flush,
   output logic [4:0]              rs1_addr,
   output logic [4:0]              rs2_addr,
   input  logic [XLEN-1:0]         rs1_data,
   input  logic [XLEN-1:0]         rs2_data,
   input  logic [NUM_FWD-1:0]      fwd_we,
   input  logic [5*NUM_FWD-1:0]    fwd_addr,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   input  logic                    ex_is_load,
   input  logic [4:0]              ex_rd,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_aluop,
   output logic [3:0]              out_alusel,
   output logic [XLEN-1:0]         out_op1,
   output logic [XLEN-1:0]         out_op2,
   output logic [4:0]              out_rd,
   output logic                    out_we,
   output logic                    out_mem_valid,
   output logic                    out_mem_rw,
   output logic [XLEN-1:0]         out_mem_data,
   output logic [XLEN/8-1:0]       out_mem_be,
   output logic                    out_mem_unsigned,
   output logic                    out_illegal,
   output logic [XLEN-1:0]         out_pc
);

   localparam int BE_W = XLEN / 8;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] imm_i, imm_s, imm_u;
   logic [7:0]      be_full;
   logic            wide_on_rv32;
   logic            uses_rs1, uses_rs2, hazard, capture;

   logic [7:0]      aluop_d,  aluop_q;
   logic [3:0]      alusel_d, alusel_q;
   logic [XLEN-1:0] op1_d,    op1_q;
   logic [XLEN-1:0] op2_d,    op2_q;
   logic            we_d,     we_q;
   logic            mv_d,     mv_q;
   logic            rw_d,     rw_q;
   logic [XLEN-1:0] mdata_d,  mdata_q;
   logic [BE_W-1:0] be_d,     be_q;
   logic            uns_d,    uns_q;
   logic            ill_d,    ill_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;

   assign opcode   = in_inst[6:0];
   assign funct3   = in_inst[14:12];
   assign rd       = in_inst[11:7];
   assign rs1_addr = in_inst[19:15];
   assign rs2_addr = in_inst[24:20];

   assign imm_i   = XLEN'($signed(in_inst[31:20]));
   assign imm_s   = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
   assign imm_u   = XLEN'($signed({in_inst[31:12], 12'h000}));
   assign be_full = be_from_width(funct3[1:0]);
   assign wide_on_rv32 = (XLEN == 32) && (funct3 == F3_D);

   id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .rs_addr_i  (rs1_addr),
      .rf_data_i  (rs1_data),
      .fwd_we_i   (fwd_we),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .rs_val_o   (rs1_val)
   );

   id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .rs_addr_i  (rs2_addr),
      .rf_data_i  (rs2_data),
      .fwd_we_i   (fwd_we),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .rs_val_o   (rs2_val)
   );

   always_comb begin
      aluop_d  = ALUOP_NOP;
      alusel_d = 4'h0;
      op1_d    = '0;
      op2_d    = '0;
      we_d     = 1'b0;
      mv_d     = 1'b0;
      rw_d     = 1'b0;
      mdata_d  = '0;
      be_d     = '0;
      uns_d    = 1'b0;
      ill_d    = 1'b0;
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      case (opcode)
         OPC_OP: begin
            aluop_d  = ALUOP_OP;
            alusel_d = {in_inst[30], funct3};
            op1_d    = rs1_val;
            op2_d    = rs2_val;
            we_d     = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_OP_IMM: begin
            aluop_d  = ALUOP_OP_IMM;
            alusel_d = {(funct3 == F3_SR) ? in_inst[30] : 1'b0, funct3};
            op1_d    = rs1_val;
            op2_d    = imm_i;
            we_d     = 1'b1;
         end
         OPC_LUI: begin
            aluop_d  = ALUOP_LUI;
            op1_d    = imm_u;
            we_d     = 1'b1;
            uses_rs1 = 1'b0;
         end
         OPC_AUIPC: begin
            aluop_d  = ALUOP_AUIPC;
            op1_d    = in_pc;
            op2_d    = imm_u;
            we_d     = 1'b1;
            uses_rs1 = 1'b0;
         end
         OPC_LOAD: begin
            aluop_d = ALUOP_LOAD;
            op1_d   = rs1_val;
            op2_d   = imm_i;
            be_d    = be_full[BE_W-1:0];
            if ((funct3 == 3'b111) || wide_on_rv32) begin
               ill_d = 1'b1;
            end else begin
               we_d  = 1'b1;
               mv_d  = 1'b1;
               uns_d = funct3[2];
            end
         end
         OPC_STORE: begin
            aluop_d  = ALUOP_STORE;
            op1_d    = rs1_val;
            op2_d    = imm_s;
            mdata_d  = rs2_val;
            be_d     = be_full[BE_W-1:0];
            uses_rs2 = 1'b1;
            if (funct3[2] || wide_on_rv32) begin
               ill_d = 1'b1;
            end else begin
               mv_d = 1'b1;
               rw_d = 1'b1;
            end
         end
         default: ill_d = 1'b1;
      endcase
      if (rd == 5'd0) begin
         we_d = 1'b0;
      end
   end

   // Load data in EX is not forwardable yet; stall the consumer one cycle.
   assign hazard = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (rs1_addr == ex_rd)) ||
                    (uses_rs2 && (rs2_addr == ex_rd)));

   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign capture  = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         aluop_q  <= '0;
         alusel_q <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         mv_q     <= 1'b0;
         rw_q     <= 1'b0;
         mdata_q  <= '0;
         be_q     <= '0;
         uns_q    <= 1'b0;
         ill_q    <= 1'b0;
         pc_q     <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (!valid_q || out_ready) begin
            valid_q <= in_valid && !hazard;
         end
         if (capture) begin
            aluop_q  <= aluop_d;
            alusel_q <= alusel_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rd_q     <= rd;
            we_q     <= we_d;
            mv_q     <= mv_d;
            rw_q     <= rw_d;
            mdata_q  <= mdata_d;
            be_q     <= be_d;
            uns_q    <= uns_d;
            ill_q    <= ill_d;
            pc_q     <= in_pc;
         end
      end
   end

   assign out_valid        = valid_q;
   assign out_aluop        = aluop_q;
   assign out_alusel       = alusel_q;
   assign out_op1          = op1_q;
   assign out_op2          = op2_q;
   assign out_rd           = rd_q;
   assign out_we           = we_q;
   assign out_mem_valid    = mv_q;
   assign out_mem_rw       = rw_q;
   assign out_mem_data     = mdata_q;
   assign out_mem_be       = be_q;
   assign out_mem_unsigned = uns_q;
   assign out_illegal      = ill_q;
   assign out_pc           = pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: XLEN=64 main instance plus an XLEN=32 instance
// sharing the same stimulus for the width-dependent illegal cases.
module tb_id_stage_pipe;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [3:0]  alusel;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rd;
      logic        we;
      logic        mv;
      logic        rw;
      logic [63:0] md;
      logic [7:0]  be;
      logic        uns;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [1:0]  fwe;
      logic [4:0]  fa0;
      logic [4:0]  fa1;
      logic [63:0] fd0;
      logic [63:0] fd1;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, ex_is_load, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, rs1_data, rs2_data, fd0, fd1;
   logic [1:0]  fwd_we;
   logic [4:0]  fa0, fa1, ex_rd;
   logic [9:0]  fwd_addr;
   logic [127:0] fwd_data;
   logic [63:0] fwd_data32;

   logic        in_ready, out_valid, out_we, out_mem_valid, out_mem_rw, out_mem_unsigned, out_illegal;
   logic [4:0]  rs1_addr, rs2_addr, out_rd;
   logic [7:0]  out_aluop, out_mem_be;
   logic [3:0]  out_alusel;
   logic [63:0] out_op1, out_op2, out_mem_data, out_pc;

   logic        i32_ready, o32_valid, o32_we, o32_mv, o32_rw, o32_uns, o32_ill;
   logic [4:0]  a32_rs1, a32_rs2, o32_rd;
   logic [7:0]  o32_aluop;
   logic [3:0]  o32_alusel, o32_be;
   logic [31:0] o32_op1, o32_op2, o32_md, o32_pc;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign fwd_addr   = {fa1, fa0};
   assign fwd_data   = {fd1, fd0};
   assign fwd_data32 = {fd1[31:0], fd0[31:0]};

   id_stage_pipe #(.XLEN(64), .NUM_FWD(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop), .out_alusel(out_alusel),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_we(out_we),
      .out_mem_valid(out_mem_valid), .out_mem_rw(out_mem_rw), .out_mem_data(out_mem_data),
      .out_mem_be(out_mem_be), .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal),
      .out_pc(out_pc)
   );

   id_stage_pipe #(.XLEN(32), .NUM_FWD(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i32_ready),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
      .rs1_addr(a32_rs1), .rs2_addr(a32_rs2), .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
      .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data32),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .out_valid(o32_valid), .out_ready(out_ready), .out_aluop(o32_aluop), .out_alusel(o32_alusel),
      .out_op1(o32_op1), .out_op2(o32_op2), .out_rd(o32_rd), .out_we(o32_we),
      .out_mem_valid(o32_mv), .out_mem_rw(o32_rw), .out_mem_data(o32_md),
      .out_mem_be(o32_be), .out_mem_unsigned(o32_uns), .out_illegal(o32_ill),
      .out_pc(o32_pc)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic chk_payload(input string tag, input exp_t e, input logic [63:0] pc);
      chk({tag, " illegal"}, out_illegal, e.ill);
      chk({tag, " we"}, out_we, e.we);
      chk({tag, " mem_valid"}, out_mem_valid, e.mv);
      chk({tag, " pc"}, out_pc, pc);
      if (!e.ill) begin
         chk({tag, " aluop"}, out_aluop, e.aluop);
         chk({tag, " op1"}, out_op1, e.op1);
         chk({tag, " op2"}, out_op2, e.op2);
         chk({tag, " unsigned"}, out_mem_unsigned, e.uns);
         if (e.aluop == 8'd1 || e.aluop == 8'd2) chk({tag, " alusel"}, out_alusel, e.alusel);
      end
      if (e.we) chk({tag, " rd"}, out_rd, e.rd);
      if (e.mv) begin
         chk({tag, " mem_rw"}, out_mem_rw, e.rw);
         chk({tag, " be"}, out_mem_be, e.be);
         if (e.rw) chk({tag, " mem_data"}, out_mem_data, e.md);
      end
   endtask

   // Reference decode, straight from the ISA field definitions.
   function automatic logic [63:0] pick(input logic [4:0] rs, input logic [63:0] rf);
      if (rs == 0) return 64'd0;
      if (fwd_we[0] && fa0 == rs) return fd0;
      if (fwd_we[1] && fa1 == rs) return fd1;
      return rf;
   endfunction

   function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc,
                                    input logic [63:0] r1d, input logic [63:0] r2d);
      exp_t e;
      logic [63:0] a, b;
      longint immi, imms, immu;
      int bytes;
      logic [2:0] f3;
      e = '0;
      f3 = inst[14:12];
      a = pick(inst[19:15], r1d);
      b = pick(inst[24:20], r2d);
      immi = longint'($signed(inst[31:20]));
      imms = longint'($signed({inst[31:25], inst[11:7]}));
      immu = longint'($signed({inst[31:12], 12'h000}));
      bytes = 1 << f3[1:0];
      e.rd = inst[11:7];
      case (inst[6:0])
         7'h33: begin e.aluop = 1; e.alusel = {inst[30], f3}; e.op1 = a; e.op2 = b; e.we = 1; end
         7'h13: begin
            e.aluop = 2; e.alusel = {(f3 == 3'd5) && inst[30], f3};
            e.op1 = a; e.op2 = immi; e.we = 1;
         end
         7'h37: begin e.aluop = 3; e.op1 = immu; e.op2 = 0; e.we = 1; end
         7'h17: begin e.aluop = 4; e.op1 = pc; e.op2 = immu; e.we = 1; end
         7'h03: begin
            e.aluop = 5; e.op1 = a; e.op2 = immi;
            if (f3 == 3'd7) e.ill = 1;
            else begin e.we = 1; e.mv = 1; e.be = 8'((1 << bytes) - 1); e.uns = f3[2]; end
         end
         7'h23: begin
            e.aluop = 6; e.op1 = a; e.op2 = imms;
            if (f3[2]) e.ill = 1;
            else begin e.mv = 1; e.rw = 1; e.md = b; e.be = 8'((1 << bytes) - 1); end
         end
         default: e.ill = 1;
      endcase
      if (e.rd == 0 || e.ill) e.we = 0;
      if (e.ill) e.mv = 0;
      return e;
   endfunction

   function automatic logic ref_hazard(input logic [31:0] inst);
      logic u1, u2;
      u1 = !(inst[6:0] == 7'h37 || inst[6:0] == 7'h17);
      u2 = (inst[6:0] == 7'h33 || inst[6:0] == 7'h23);
      return in_valid && ex_is_load && ex_rd != 0 &&
             ((u1 && inst[19:15] == ex_rd) || (u2 && inst[24:20] == ex_rd));
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t tbl[15];
   logic        m_valid;
   exp_t        m_e;
   logic [63:0] m_pc;
   logic [31:0] rnd;

   initial begin
      tbl[0]  = '{32'h002081B3, 64'h100, 64'd5, 64'd7, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd1, 4'h0, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[1]  = '{32'h00108093, 64'h104, 64'h99, 64'd0, 2'b11, 5'd1, 5'd1, 64'hA, 64'hB,
                  '{8'd2, 4'h0, 64'hA, 64'd1, 5'd1, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[2]  = '{32'h00500213, 64'h108, 64'h33, 64'd0, 2'b01, 5'd0, 5'd0, 64'h55, 64'd0,
                  '{8'd2, 4'h0, 64'd0, 64'd5, 5'd4, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[3]  = '{32'hFE20AE23, 64'h10C, 64'h1000, 64'h1122334455667788, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd6, 4'h0, 64'h1000, 64'hFFFFFFFFFFFFFFFC, 5'd0, 1'b0, 1'b1, 1'b1,
                    64'h1122334455667788, 8'h0F, 1'b0, 1'b0}};
      tbl[4]  = '{32'h800002B7, 64'h110, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd3, 4'h0, 64'hFFFFFFFF80000000, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[5]  = '{32'h12345397, 64'h4000, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd4, 4'h0, 64'h4000, 64'h12345000, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[6]  = '{32'h4034D413, 64'h118, 64'hF0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd2, 4'hD, 64'hF0, 64'h403, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[7]  = '{32'h40C58533, 64'h11C, 64'd9, 64'd4, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd1, 4'h8, 64'd9, 64'd4, 5'd10, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[8]  = '{32'h00813283, 64'h120, 64'h2000, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd5, 4'h0, 64'h2000, 64'd8, 5'd5, 1'b1, 1'b1, 1'b0, 64'd0, 8'hFF, 1'b0, 1'b0}};
      tbl[9]  = '{32'hFFF1C303, 64'h124, 64'h3000, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd5, 4'h0, 64'h3000, 64'hFFFFFFFFFFFFFFFF, 5'd6, 1'b1, 1'b1, 1'b0, 64'd0, 8'h01, 1'b1, 1'b0}};
      tbl[10] = '{32'h0000007F, 64'h128, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd0, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1}};
      tbl[11] = '{32'h00017183, 64'h12C, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd0, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1}};
      tbl[12] = '{32'h00114023, 64'h130, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd0, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1}};
      tbl[13] = '{32'h00208033, 64'h134, 64'd1, 64'd2, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0,
                  '{8'd1, 4'h0, 64'd1, 64'd2, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};
      tbl[14] = '{32'hFFF1E113, 64'h138, 64'h77, 64'd0, 2'b10, 5'd3, 5'd3, 64'h1234, 64'hBEEF,
                  '{8'd2, 4'h6, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 5'd2, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0}};

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
      out_ready = 1'b1; in_inst = 32'd0; in_pc = 64'd0; rs1_data = 64'd0; rs2_data = 64'd0;
      fwd_we = 2'b00; fa0 = 5'd0; fa1 = 5'd0; fd0 = 64'd0; fd1 = 64'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset op1", out_op1, 64'd0);
      chk("reset illegal", out_illegal, 1'b0);
      chk("reset pc", out_pc, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready", in_ready, 1'b1);
      @(negedge clk);

      // Table-driven single-instruction vectors, back-to-back captures
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1; in_inst = tbl[i].inst; in_pc = tbl[i].pc;
         rs1_data = tbl[i].r1; rs2_data = tbl[i].r2;
         fwd_we = tbl[i].fwe; fa0 = tbl[i].fa0; fa1 = tbl[i].fa1; fd0 = tbl[i].fd0; fd1 = tbl[i].fd1;
         #1;
         chk($sformatf("tbl%0d rs1_addr", i), rs1_addr, tbl[i].inst[19:15]);
         chk($sformatf("tbl%0d rs2_addr", i), rs2_addr, tbl[i].inst[24:20]);
         step();
         chk($sformatf("tbl%0d valid", i), out_valid, 1'b1);
         chk_payload($sformatf("tbl%0d", i), tbl[i].e, tbl[i].pc);
      end

      // Load-use hazard: ADD x6,x5,x1 behind a load to x5
      in_inst = 32'h00128333; in_pc = 64'h200; rs1_data = 64'hDEAD; rs2_data = 64'h11;
      fwd_we = 2'b00; ex_is_load = 1'b1; ex_rd = 5'd5;
      #1;
      chk("hazard in_ready", in_ready, 1'b0);
      step();
      chk("hazard bubble", out_valid, 1'b0);
      ex_is_load = 1'b0; fwd_we = 2'b01; fa0 = 5'd5; fd0 = 64'h77;
      #1;
      chk("post-hazard in_ready", in_ready, 1'b1);
      step();
      chk("post-hazard valid", out_valid, 1'b1);
      chk("post-hazard op1", out_op1, 64'h77);
      chk("post-hazard op2", out_op2, 64'h11);
      chk("post-hazard rd", out_rd, 5'd6);

      // Backpressure: held output, then flush with a pending input
      out_ready = 1'b0; in_inst = 32'h002081B3; in_pc = 64'h300; fwd_we = 2'b00;
      rs1_data = 64'd5; rs2_data = 64'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d in_ready", i), in_ready, 1'b0);
         step();
         chk($sformatf("stall%0d valid", i), out_valid, 1'b1);
         chk($sformatf("stall%0d op1", i), out_op1, 64'h77);
         chk($sformatf("stall%0d rd", i), out_rd, 5'd6);
         chk($sformatf("stall%0d pc", i), out_pc, 64'h200);
      end
      flush = 1'b1;
      step();
      chk("flush valid", out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("flush nothing captured", out_valid, 1'b0);
      chk("flush pc untouched", out_pc, 64'h200);
      in_valid = 1'b1; flush = 1'b1;
      step();
      chk("flush beats free capture", out_valid, 1'b0);
      flush = 1'b0;

      // Width-dependent legality: SD, SW, LD on both widths
      in_inst = 32'hFE20BE23; rs1_data = 64'h1000; rs2_data = 64'h1122334455667788;
      step();
      chk("sd64 mem_valid", out_mem_valid, 1'b1);
      chk("sd64 be", out_mem_be, 8'hFF);
      chk("sd64 illegal", out_illegal, 1'b0);
      chk("sd32 valid", o32_valid, 1'b1);
      chk("sd32 illegal", o32_ill, 1'b1);
      chk("sd32 mem_valid", o32_mv, 1'b0);
      chk("sd32 we", o32_we, 1'b0);
      in_inst = 32'hFE20AE23;
      step();
      chk("sw32 illegal", o32_ill, 1'b0);
      chk("sw32 mem_valid", o32_mv, 1'b1);
      chk("sw32 be", o32_be, 4'hF);
      chk("sw32 op2", o32_op2, 32'hFFFFFFFC);
      chk("sw32 mem_data", o32_md, 32'h55667788);
      in_inst = 32'h00813283;
      step();
      chk("ld32 illegal", o32_ill, 1'b1);
      chk("ld32 mem_valid", o32_mv, 1'b0);
      chk("ld64 illegal", out_illegal, 1'b0);

      // Randomized traffic against the reference model
      in_valid = 1'b0;
      step();
      m_valid = 1'b0; m_e = '0; m_pc = 64'd0;
      for (int c = 0; c < 600; c++) begin
         chk("rnd valid", out_valid, m_valid);
         if (m_valid) chk_payload("rnd", m_e, m_pc);
         rnd = $urandom();
         in_inst = rnd;
         case ($urandom_range(0, 6))
            0: in_inst[6:0] = 7'h33;
            1: in_inst[6:0] = 7'h13;
            2: in_inst[6:0] = 7'h37;
            3: in_inst[6:0] = 7'h17;
            4: in_inst[6:0] = 7'h03;
            5: in_inst[6:0] = 7'h23;
            default: in_inst[6:0] = 7'h5B;
         endcase
         in_inst[11:7]  = 5'($urandom_range(0, 3));
         in_inst[19:15] = 5'($urandom_range(0, 3));
         in_inst[24:20] = 5'($urandom_range(0, 3));
         in_pc    = {$urandom(), $urandom()};
         rs1_data = {$urandom(), $urandom()};
         rs2_data = {$urandom(), $urandom()};
         fd0      = {$urandom(), $urandom()};
         fd1      = {$urandom(), $urandom()};
         fwd_we   = 2'($urandom_range(0, 3));
         fa0      = 5'($urandom_range(0, 3));
         fa1      = 5'($urandom_range(0, 3));
         ex_is_load = ($urandom_range(0, 3) == 0);
         ex_rd      = 5'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 15) == 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         in_valid   = ($urandom_range(0, 4) != 0);
         #1;
         chk("rnd in_ready", in_ready, (!m_valid || out_ready) && !ref_hazard(in_inst));
         if (flush) m_valid = 1'b0;
         else if (!m_valid || out_ready) begin
            if (in_valid && !ref_hazard(in_inst)) begin
               m_valid = 1'b1;
               m_e = ref_dec(in_inst, in_pc, rs1_data, rs2_data);
               m_pc = in_pc;
            end else m_valid = 1'b0;
         end
         step();
      end

      // Asynchronous reset with a valid op in flight
      flush = 1'b0; ex_is_load = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      in_inst = 32'h002081B3; in_pc = 64'h500; rs1_data = 64'd5; rs2_data = 64'd7; fwd_we = 2'b00;
      step();
      chk("pre-reset valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset valid", out_valid, 1'b0);
      chk("async reset op1", out_op1, 64'd0);
      chk("async reset we", out_we, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("after reset valid", out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
